vga_timing: RTL

Free-running raster timing generator feeding the display pixel stages (grid overlay, board renderer, colour mux) with `hcount`/`vcount` and sync/blank strobes. Produces 800x600 @ 72 Hz timing from the 50 MHz `vclk`. Also provides sync/blank copies delayed to match the registered pixel stages downstream, so the final RGB and syncs reach the DAC aligned.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_sync_delay.sv | 39 +++
 rtl/vga_timing.sv | 117 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, count types and the sync/blank bundle used by the
// raster generator and its aligned delay line.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef logic [HCNT_W-1:0] hcount_t;
    typedef logic [VCNT_W-1:0] vcount_t;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_bus_t;

    // Idle bundle: blanked, both syncs at their inactive level.
    function automatic sync_bus_t sync_idle(input logic pol);
        sync_bus_t s;
        s.blank = 1'b1;
        s.hsync = ~pol;
        s.vsync = ~pol;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: counts, strobes and pipeline-aligned sync/blank copies.
interface vga_timing_if;
    import vga_pkg::*;

    hcount_t hcount;
    vcount_t vcount;
    logic    hsync;
    logic    vsync;
    logic    blank;
    logic    line_start;
    logic    frame_start;
    logic    hsync_d;
    logic    vsync_d;
    logic    blank_d;

    modport master (
        output hcount, vcount, hsync, vsync, blank,
        output line_start, frame_start, hsync_d, vsync_d, blank_d
    );

    modport slave (
        input hcount, vcount, hsync, vsync, blank,
        input line_start, frame_start, hsync_d, vsync_d, blank_d
    );

endinterface

// File: rtl/vga_timing_sync_delay.sv
// Fixed-depth shift register that re-times sync/blank to match the registered
// pixel stages; depth 0 degenerates to a straight wire.
module sync_delay
    import vga_pkg::*;
#(
    parameter int        DEPTH   = 1,
    parameter sync_bus_t RST_VAL = 3'b100
) (
    input  logic      vclk,
    input  logic      rst,
    input  sync_bus_t d_i,
    output sync_bus_t q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            sync_bus_t stage_q [DEPTH];

            // Shift chain, flushed to the idle bundle on reset.
            always_ff @(posedge vclk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: pixel/line counters with zero-skew
// sync, blank and start strobes, plus pipeline-delayed sync/blank copies.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FRONT   = H_FRONT_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BACK    = H_BACK_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter logic SYNC_POL  = 1'b1,
    parameter int   PIPE_DLY  = 1
) (
    input  logic         vclk,
    input  logic         rst,
    vga_timing_if.master vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
    localparam hcount_t H_VIS    = hcount_t'(H_VISIBLE);
    localparam vcount_t V_VIS    = vcount_t'(V_VISIBLE);
    localparam hcount_t HS_FIRST = hcount_t'(H_VISIBLE + H_FRONT);
    localparam hcount_t HS_LAST  = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam vcount_t VS_FIRST = vcount_t'(V_VISIBLE + V_FRONT);
    localparam vcount_t VS_LAST  = vcount_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam sync_bus_t IDLE = sync_idle(SYNC_POL);

    hcount_t   hcount_q, hcount_d;
    vcount_t   vcount_q, vcount_d;
    logic      started_q;
    logic      hs_q, hs_d;
    logic      vs_q, vs_d;
    logic      blk_q, blk_d;
    logic      ls_q, ls_d;
    logic      fs_q, fs_d;
    sync_bus_t dly_in_s;
    sync_bus_t dly_out_s;

    // Next coordinate, then every strobe decoded from that same coordinate.
    // The first clock after reset re-presents (0,0) so it carries the start strobes.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (!started_q) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end else begin
            hcount_d = hcount_q + 11'd1;
        end

        hs_d  = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vs_d  = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        blk_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
        ls_d  = (hcount_d == 11'd0);
        fs_d  = (hcount_d == 11'd0) && (vcount_d == 10'd0);
    end

    // Counter and strobe registers.
    always_ff @(posedge vclk) begin
        if (rst) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            started_q <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            blk_q     <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            started_q <= 1'b1;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blk_q     <= blk_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end
    end

    assign dly_in_s.blank = blk_q;
    assign dly_in_s.hsync = hs_q;
    assign dly_in_s.vsync = vs_q;

    sync_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL (IDLE)
    ) u_sync_delay (
        .vclk (vclk),
        .rst  (rst),
        .d_i  (dly_in_s),
        .q_o  (dly_out_s)
    );

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.blank       = blk_q;
    assign vif.line_start  = ls_q;
    assign vif.frame_start = fs_q;
    assign vif.hsync_d     = dly_out_s.hsync;
    assign vif.vsync_d     = dly_out_s.vsync;
    assign vif.blank_d     = dly_out_s.blank;

endmodule
